// File: rtl/fb_pixel_fetch.sv
// Framebuffer scan-out fetch: streams sequential words into a 2-word prefetch buffer and unpacks them LSB-first into pixels.
// Pixel response is registered one cycle after pix_req; there is no backpressure, and an empty buffer yields pixel 0 plus a sticky underflow.
module fb_pixel_fetch #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          PIX_BITS  = 1,
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                pix_req,
    output logic [31:0]         vaddr,
    input  logic [31:0]         vdata,
    output logic                vrd,
    output logic [PIX_BITS-1:0] pixel,
    output logic                pix_valid,
    output logic                ready,
    output logic                underflow,
    output logic                frame_done
);

    localparam int PPW   = 32 / PIX_BITS;
    localparam int WORDS = H_ACTIVE * V_ACTIVE * PIX_BITS / 32;
    localparam int WCW   = $clog2(WORDS + 1);
    localparam int IW    = $clog2(PPW);
    localparam logic [WCW-1:0] WORDS_W  = WCW'(WORDS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(PPW - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [31:0]    word0, word1;
    logic [1:0]     cnt;
    logic           inflight;
    logic [WCW-1:0] issued;
    logic [IW-1:0]  pix_idx;

    logic          active, words_left, push, serve, consume, pop, done_cond, underflow_set;
    logic [31:0]   shamt;
    logic [PIX_BITS-1:0] cur_pix;

    assign active     = (state == PRIME) || (state == RUN);
    assign words_left = (issued != WORDS_W);

    // frame_start suppresses new reads so nothing issued before the restart can land afterwards
    assign vrd = active && !frame_start && !inflight && (cnt != 2'd2) && words_left;

    // A return coinciding with frame_start belongs to the aborted frame and is dropped
    assign push    = active && inflight && !frame_start;
    assign serve   = pix_req && !frame_start;
    assign consume = serve && active && (cnt != 2'd0);
    assign pop     = consume && (pix_idx == LAST_IDX);

    // Once every word is fetched and drained, a stray request is end-of-frame, not underflow
    assign underflow_set = serve && active && (cnt == 2'd0) && (words_left || inflight);
    assign done_cond     = (state == RUN) && !words_left && !inflight && (cnt == 2'd0);

    assign shamt   = 32'(pix_idx) * 32'(PIX_BITS);
    assign cur_pix = PIX_BITS'(word0 >> shamt);

    assign ready      = (cnt != 2'd0);
    assign frame_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            PRIME:   if (push) state_nxt = RUN;
            RUN:     if (done_cond) state_nxt = DONE;
            default: state_nxt = state;
        endcase
        if (frame_start) state_nxt = PRIME;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            vaddr     <= BASE_ADDR;
            word0     <= '0;
            word1     <= '0;
            cnt       <= 2'd0;
            inflight  <= 1'b0;
            issued    <= '0;
            pix_idx   <= '0;
            pixel     <= '0;
            pix_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= vrd;
            if (frame_start) begin
                vaddr     <= BASE_ADDR;
                cnt       <= 2'd0;
                issued    <= '0;
                pix_idx   <= '0;
                pixel     <= '0;
                pix_valid <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (vrd) begin
                    vaddr  <= vaddr + 32'd4;
                    issued <= issued + WCW'(1);
                end

                case ({push, pop})
                    2'b10: begin
                        if (cnt == 2'd0) word0 <= vdata;
                        else             word1 <= vdata;
                        cnt <= cnt + 2'd1;
                    end
                    2'b01: begin
                        word0 <= word1;
                        cnt   <= cnt - 2'd1;
                    end
                    2'b11: begin
                        if (cnt == 2'd1) begin
                            word0 <= vdata;
                        end else begin
                            word0 <= word1;
                            word1 <= vdata;
                        end
                    end
                    default: ;
                endcase

                pix_valid <= serve;
                pixel     <= consume ? cur_pix : '0;
                if (consume)       pix_idx   <= pix_idx + IW'(1);
                if (underflow_set) underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Directed bench for fb_pixel_fetch: a default-size instance for priming, unpack, underflow and restart,
// and a 4-word-frame instance for end-of-frame behaviour.
module tb_fb_pixel_fetch;

    logic        clk;
    logic        reset;

    logic        fs, req;
    logic [31:0] vaddr, vdata;
    logic        vrd, pixel, pix_valid, ready, underflow, frame_done;

    logic        fs_s, req_s;
    logic [31:0] vaddr_s, vdata_s;
    logic        vrd_s, pixel_s, pix_valid_s, ready_s, underflow_s, frame_done_s;

    logic [31:0] mem [16];
    logic [31:0] rd_log [8];
    int          n_rd;

    int n_cmp;
    int n_err;

    fb_pixel_fetch dut (
        .clk(clk), .reset(reset), .frame_start(fs), .pix_req(req),
        .vaddr(vaddr), .vdata(vdata), .vrd(vrd), .pixel(pixel),
        .pix_valid(pix_valid), .ready(ready), .underflow(underflow), .frame_done(frame_done)
    );

    fb_pixel_fetch #(.BASE_ADDR(32'h0), .PIX_BITS(1), .H_ACTIVE(64), .V_ACTIVE(2)) dut_s (
        .clk(clk), .reset(reset), .frame_start(fs_s), .pix_req(req_s),
        .vaddr(vaddr_s), .vdata(vdata_s), .vrd(vrd_s), .pixel(pixel_s),
        .pix_valid(pix_valid_s), .ready(ready_s), .underflow(underflow_s), .frame_done(frame_done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle read latency RAM model plus a log of the small instance's reads
    always @(posedge clk) begin
        if (vrd)   vdata   <= mem[vaddr[5:2]];
        if (vrd_s) begin
            vdata_s <= mem[vaddr_s[5:2]];
            if (n_rd < 8) rd_log[n_rd] <= vaddr_s;
            n_rd <= n_rd + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  a5;
        logic [31:0] w;
        logic        found;
        int          k;

        n_cmp = 0;
        n_err = 0;
        n_rd  = 0;
        a5    = 8'hA5;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * i;
        mem[0] = 32'hA5A5_A5A5;
        mem[1] = 32'hFFFF_0000;
        mem[2] = 32'h1234_5678;
        mem[3] = 32'h0F0F_00FF;
        mem[8] = 32'h5A5A_5A5A;

        fs = 0; req = 0; fs_s = 0; req_s = 0;
        reset = 1;

        // Reset then idle
        repeat (2) tick();
        reset = 0;
        @(negedge clk);
        chk("rst_vaddr", vaddr, 32'h0);
        chk("rst_vrd", vrd, 0);
        chk("rst_ready", ready, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_s_frame_done", frame_done_s, 0);

        req = 1;
        tick();
        req = 0;
        @(negedge clk);
        chk("idle_pix", {pix_valid, pixel}, 2'b10);
        chk("idle_underflow", underflow, 0);
        tick();
        @(negedge clk);
        chk("idle_novalid", pix_valid, 0);

        // Priming latency
        fs = 1;
        tick();
        fs = 0;
        @(negedge clk);
        chk("prime_c1_vrd", vrd, 1);
        chk("prime_c1_vaddr", vaddr, 32'h0);
        tick();
        @(negedge clk);
        chk("prime_c2_vrd", vrd, 0);
        chk("prime_c2_ready", ready, 0);
        tick();
        @(negedge clk);
        chk("prime_c3_vrd", vrd, 1);
        chk("prime_c3_vaddr", vaddr, 32'h4);
        chk("prime_c3_ready", ready, 1);

        // Unpack words 0 and 1 back to back
        req = 1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (i == 63) req = 0;
            @(negedge clk);
            if (i < 32) chk("unpack_w0", {pix_valid, pixel}, {1'b1, a5[i % 8]});
            else        chk("unpack_w1", {pix_valid, pixel}, {1'b1, (i - 32) >= 16});
        end
        chk("unpack_underflow", underflow, 0);

        // Underflow: request before the first word lands
        fs = 1;
        tick();
        fs = 0;
        req = 1;
        tick();
        req = 0;
        @(negedge clk);
        chk("uf_pix", {pix_valid, pixel}, 2'b10);
        chk("uf_flag", underflow, 1);
        tick();
        @(negedge clk);
        chk("uf_ready", ready, 1);
        req = 1;
        tick();
        @(negedge clk);
        chk("uf_idx_hold0", {pix_valid, pixel}, 2'b11);
        tick();
        req = 0;
        @(negedge clk);
        chk("uf_idx_hold1", {pix_valid, pixel}, 2'b10);
        chk("uf_sticky", underflow, 1);
        fs = 1;
        tick();
        fs = 0;
        @(negedge clk);
        chk("uf_cleared", underflow, 0);
        tick();
        tick();

        // Mid-frame restart while the read of 0x20 is in flight
        req = 1;
        found = 0;
        k = 0;
        while (!found && k < 400) begin
            tick();
            @(negedge clk);
            if (vrd && vaddr == 32'h20) found = 1;
            k++;
        end
        chk("restart_found_0x20", found, 1);
        tick();
        fs = 1;
        req = 1;
        tick();
        fs = 0;
        req = 0;
        @(negedge clk);
        chk("restart_drop_req", pix_valid, 0);
        chk("restart_vrd", vrd, 1);
        chk("restart_vaddr", vaddr, 32'h0);
        chk("restart_ready", ready, 0);
        chk("restart_underflow", underflow, 0);
        tick();
        tick();
        @(negedge clk);
        chk("restart_c3_ready", ready, 1);
        chk("restart_c3_vaddr", vaddr, 32'h4);
        req = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) req = 0;
            @(negedge clk);
            chk("restart_w0_pix", {pix_valid, pixel}, {1'b1, a5[i]});
        end

        // Reset mid-operation
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("midrst_vrd", vrd, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_vaddr", vaddr, 32'h0);
        tick();
        @(negedge clk);
        chk("midrst_still_idle", {vrd, ready}, 2'b00);

        // Full 4-word frame on the small instance
        fs_s = 1;
        tick();
        fs_s = 0;
        @(negedge clk);
        k = 0;
        while (!ready_s && k < 10) begin
            tick();
            @(negedge clk);
            k++;
        end
        chk("ff_ready", ready_s, 1);
        req_s = 1;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (i == 127) req_s = 0;
            @(negedge clk);
            w = mem[i / 32];
            chk("ff_pix", {pix_valid_s, pixel_s}, {1'b1, w[i % 32]});
        end
        k = 0;
        while (!frame_done_s && k < 10) begin
            tick();
            @(negedge clk);
            k++;
        end
        chk("ff_frame_done", frame_done_s, 1);
        chk("ff_nreads", n_rd, 4);
        chk("ff_rd0", rd_log[0], 32'h0);
        chk("ff_rd1", rd_log[1], 32'h4);
        chk("ff_rd2", rd_log[2], 32'h8);
        chk("ff_rd3", rd_log[3], 32'hC);
        chk("ff_underflow", underflow_s, 0);

        req_s = 1;
        tick();
        req_s = 0;
        @(negedge clk);
        chk("ff_extra_pix", {pix_valid_s, pixel_s}, 2'b10);
        chk("ff_extra_underflow", underflow_s, 0);
        chk("ff_extra_vrd", vrd_s, 0);
        chk("ff_extra_nreads", n_rd, 4);
        chk("ff_extra_done", frame_done_s, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
